// File: rtl/text_console_pkg.sv
// Shared types and control-code constants for the character-cell text console.
package text_console_pkg;

    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_FF    = 7'h0C;
    localparam logic [6:0] CH_SPACE = 7'h20;

    typedef enum logic [1:0] {CLEAR, CLRLINE, IDLE} t_con_state;

    typedef struct packed {
        logic       inverse;
        logic [6:0] code;
    } t_cell;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/font.sv
// Compact 8x16 glyph ROM: 'A' is drawn explicitly, other visible codes use a code-derived stripe pattern.
module font (
    input  logic [6:0] char_code,
    input  logic [3:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [7:0] bits;

    always_comb begin
        bits = '0;
        if (char_code == 7'h41) begin
            case (row)
                4'd2:                      bits = 8'h18;
                4'd3:                      bits = 8'h3C;
                4'd4, 4'd5, 4'd6:          bits = 8'h66;
                4'd7:                      bits = 8'h7E;
                4'd8, 4'd9, 4'd10, 4'd11:  bits = 8'h66;
                default:                   bits = '0;
            endcase
        end else if (char_code > 7'h20 && char_code < 7'h7F && row >= 4'd2 && row <= 4'd13) begin
            bits = row[0] ? {char_code, 1'b0} : {1'b0, char_code};
        end
    end

    assign pixel = bits[3'd7 - col];

endmodule

// File: rtl/text_cell_ram.sv
// Simple dual-port cell buffer: one write port, one registered read-first read port.
module text_cell_ram #(
    parameter int DEPTH = 240,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_console.sv
// Character-cell text console: handshake character input into a scrolling cell buffer,
// two-stage pixel lookup for the video driver.
module text_console
    import text_console_pkg::*;
#(
    parameter int                    SCREEN_WIDTH  = 240,
    parameter int                    SCREEN_HEIGHT = 135,
    parameter int                    TILE_WIDTH    = 8,
    parameter int                    TILE_HEIGHT   = 16,
    parameter int                    PIXEL_BITS    = 16,
    parameter logic [PIXEL_BITS-1:0] FG_COL        = '1,
    parameter logic [PIXEL_BITS-1:0] BG_COL        = '0,
    parameter int                    SCROLL        = 1,
    parameter int                    BLINK_CYCLES  = 13_500_000
) (
    input  logic                                          in_clk,
    input  logic                                          in_rst,
    input  logic [6:0]                                    in_char,
    input  logic                                          in_char_valid,
    input  logic                                          in_inverse,
    output logic                                          out_char_ready,
    input  logic                                          in_show_cursor,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]               in_hpix,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0]              in_vpix,
    output logic [PIXEL_BITS-1:0]                         out_pixel,
    output logic [$clog2(SCREEN_WIDTH/TILE_WIDTH)-1:0]    out_cursor_x,
    output logic [$clog2(SCREEN_HEIGHT/TILE_HEIGHT)-1:0]  out_cursor_y
);

    localparam int COLS  = SCREEN_WIDTH / TILE_WIDTH;
    localparam int ROWS  = SCREEN_HEIGHT / TILE_HEIGHT;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);

    t_con_state     state;
    logic [AW-1:0]  cnt;
    logic [XW-1:0]  cur_x;
    logic [YW-1:0]  cur_y;
    logic [YW-1:0]  row_offs;
    logic [YW-1:0]  clr_row;
    logic [31:0]    blink_cnt;
    logic           blink_phase;

    logic           accept, printable, at_eol, at_bottom, do_nl;
    logic           we;
    logic [AW-1:0]  waddr, raddr;
    t_cell          wdata, rd_cell;

    int unsigned    tile_x, tile_y;
    logic           in_range;
    logic           s1_valid, s1_cursor;
    logic [2:0]     s1_gx;
    logic [3:0]     s1_gy;
    logic           glyph_bit;

    // row and offs are logical row and scroll offset; the result is the physical cell address
    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row, input int unsigned col,
                                                input logic [YW-1:0] offs);
        return AW'(((32'(row) + 32'(offs)) % ROWS) * COLS + col);
    endfunction

    assign out_char_ready = (state == IDLE);
    assign accept         = out_char_ready && in_char_valid;
    assign printable      = is_printable(in_char);
    assign at_eol         = (32'(cur_x) == COLS - 1);
    assign at_bottom      = (32'(cur_y) == ROWS - 1);
    assign do_nl          = accept && ((printable && at_eol) || in_char == CH_LF);
    assign out_cursor_x   = cur_x;
    assign out_cursor_y   = cur_y;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '{inverse: 1'b0, code: CH_SPACE};
        case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
            end
            CLRLINE: begin
                we    = 1'b1;
                waddr = cell_addr(clr_row, 32'(cnt), '0);
            end
            default: begin
                if (accept && printable) begin
                    we    = 1'b1;
                    waddr = cell_addr(cur_y, 32'(cur_x), row_offs);
                    wdata = '{inverse: in_inverse, code: in_char};
                end
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state    <= CLEAR;
            cnt      <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            row_offs <= '0;
            clr_row  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (32'(cnt) == CELLS - 1) begin
                        cnt      <= '0;
                        cur_x    <= '0;
                        cur_y    <= '0;
                        row_offs <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLRLINE: begin
                    if (32'(cnt) == COLS - 1) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (do_nl) begin
                            cur_x <= '0;
                            if (!at_bottom) begin
                                cur_y <= cur_y + 1'b1;
                            end else if (SCROLL != 0) begin
                                // the old top physical row becomes the new bottom row
                                row_offs <= YW'((32'(row_offs) + 1) % ROWS);
                                clr_row  <= row_offs;
                                cnt      <= '0;
                                state    <= CLRLINE;
                            end else begin
                                cur_y <= '0;
                            end
                        end else if (printable) begin
                            cur_x <= cur_x + 1'b1;
                        end else if (in_char == CH_CR) begin
                            cur_x <= '0;
                        end else if (in_char == CH_BS) begin
                            if (cur_x != '0)
                                cur_x <= cur_x - 1'b1;
                        end else if (in_char == CH_FF) begin
                            cnt   <= '0;
                            state <= CLEAR;
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (BLINK_CYCLES != 0) begin
            if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1;
            end
        end
    end

    always_comb begin
        tile_x   = 32'(in_hpix) / TILE_WIDTH;
        tile_y   = 32'(in_vpix) / TILE_HEIGHT;
        in_range = (tile_x < COLS) && (tile_y < ROWS);
        raddr    = in_range ? cell_addr(YW'(tile_y), tile_x, row_offs) : '0;
    end

    text_cell_ram #(
        .DEPTH (CELLS),
        .WIDTH (8)
    ) u_cells (
        .clk   (in_clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rd_cell)
    );

    // stage 1 runs alongside the registered cell read
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            s1_valid  <= 1'b0;
            s1_cursor <= 1'b0;
            s1_gx     <= '0;
            s1_gy     <= '0;
        end else begin
            s1_valid  <= in_range;
            s1_cursor <= in_show_cursor && blink_phase &&
                         (tile_x == 32'(cur_x)) && (tile_y == 32'(cur_y));
            s1_gx     <= 3'(32'(in_hpix) % TILE_WIDTH);
            s1_gy     <= 4'(32'(in_vpix) % TILE_HEIGHT);
        end
    end

    font u_font (
        .char_code (rd_cell.code),
        .row       (s1_gy),
        .col       (s1_gx),
        .pixel     (glyph_bit)
    );

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst)
            out_pixel <= BG_COL;
        else
            out_pixel <= (s1_valid && (glyph_bit ^ rd_cell.inverse ^ s1_cursor)) ? FG_COL : BG_COL;
    end

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console against a logical-screen reference model.
module tb_text_console;

    localparam int          COLS  = 30;
    localparam int          ROWS  = 8;
    localparam int          BLINK = 4;
    localparam logic [15:0] FG    = 16'hFFFF;
    localparam logic [15:0] BG    = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  in_char = '0;
    logic        in_char_valid = 1'b0;
    logic        in_inverse = 1'b0;
    logic        out_char_ready;
    logic        in_show_cursor = 1'b0;
    logic [7:0]  in_hpix = '0;
    logic [7:0]  in_vpix = '0;
    logic [15:0] out_pixel;
    logic [4:0]  out_cursor_x;
    logic [2:0]  out_cursor_y;

    text_console #(
        .SCROLL       (1),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .in_clk         (clk),
        .in_rst         (rst_n),
        .in_char        (in_char),
        .in_char_valid  (in_char_valid),
        .in_inverse     (in_inverse),
        .out_char_ready (out_char_ready),
        .in_show_cursor (in_show_cursor),
        .in_hpix        (in_hpix),
        .in_vpix        (in_vpix),
        .out_pixel      (out_pixel),
        .out_cursor_x   (out_cursor_x),
        .out_cursor_y   (out_cursor_y)
    );

    always #5 clk = ~clk;

    // clock edges since reset release, used to predict the blink phase
    int unsigned cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model: logical screen, scrolled by shifting rows
    logic [7:0] scr [ROWS][COLS];
    int cx, cy;

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        cx = 0;
        cy = 0;
    endtask

    task automatic model_newline();
        cx = 0;
        if (cy < ROWS - 1) begin
            cy++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r + 1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS - 1][c] = 8'h20;
        end
    endtask

    task automatic model_accept(input logic [6:0] c, input logic inv);
        if (c >= 7'h20 && c <= 7'h7E) begin
            scr[cy][cx] = {inv, c};
            if (cx == COLS - 1) model_newline();
            else cx++;
        end else begin
            case (c)
                7'h0A: model_newline();
                7'h0D: cx = 0;
                7'h08: if (cx > 0) cx--;
                7'h0C: model_clear();
                default: ;
            endcase
        end
    endtask

    function automatic bit glyph(input int code, input int r, input int c);
        byte unsigned a_rows [16] = '{8'h00, 8'h00, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h7E,
                                      8'h66, 8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
        int b = 0;
        if (code == 'h41) b = a_rows[r];
        else if (code >= 'h21 && code <= 'h7E && r >= 2 && r <= 13) b = (r % 2 == 1) ? code * 2 : code;
        return ((b >> (7 - c)) & 1) == 1;
    endfunction

    function automatic logic [15:0] model_pixel(input int x, input int y, input int unsigned cnow);
        int tx = x / 8;
        int ty = y / 16;
        bit g, inv, cur;
        if (tx >= COLS || ty >= ROWS) return BG;
        g   = glyph(int'(scr[ty][tx][6:0]), y % 16, x % 8);
        inv = scr[ty][tx][7];
        cur = in_show_cursor && (((cnow / BLINK) % 2) == 0) && tx == cx && ty == cy;
        return (g ^ inv ^ cur) ? FG : BG;
    endfunction

    // ---------------- stimulus helpers
    task automatic send(input logic [6:0] c, input logic inv);
        int n = 0;
        while (!out_char_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!out_char_ready) begin
            check("send_ready_timeout", 32'(out_char_ready), 32'd1);
            return;
        end
        in_char       = c;
        in_inverse    = inv;
        in_char_valid = 1'b1;
        @(negedge clk);
        in_char_valid = 1'b0;
        model_accept(c, inv);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (!out_char_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_cursor(input string name, input int ex, input int ey);
        check(name, {out_cursor_x, out_cursor_y}, {5'(ex), 3'(ey)});
    endtask

    task automatic pix_at(input int x, input int y, output logic [15:0] p);
        in_hpix = 8'(x);
        in_vpix = 8'(y);
        @(negedge clk);
        @(negedge clk);
        p = out_pixel;
    endtask

    // mode 0: random coords, 1: fixed (x0,y0), 2: raster of one tile row starting at y0, 3: one cell at tile (x0,y0)
    task automatic stream(input string name, input int n, input int mode, input int x0, input int y0);
        logic [15:0] expq [$];
        int x, y;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                case (mode)
                    0: begin x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255)); end
                    1: begin x = x0; y = y0; end
                    2: begin x = i % 240; y = y0 + i / 240; end
                    default: begin x = x0 * 8 + i % 8; y = y0 * 16 + i / 8; end
                endcase
                in_hpix = 8'(x);
                in_vpix = 8'(y);
                expq.push_back(model_pixel(x, y, cyc));
            end
            @(negedge clk);
            if (i >= 1) check(name, 32'(out_pixel), 32'(expq.pop_front()));
        end
    endtask

    typedef struct {
        logic [6:0] ch;
        logic       inv;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vecs [12];
    int n;
    logic [15:0] p;
    logic [6:0] c;

    initial begin
        vecs = '{
            '{7'h48, 1'b0, 1, 0},   // 'H'
            '{7'h69, 1'b0, 2, 0},   // 'i'
            '{7'h08, 1'b0, 1, 0},
            '{7'h08, 1'b0, 0, 0},
            '{7'h08, 1'b0, 0, 0},   // backspace at column 0
            '{7'h71, 1'b1, 1, 0},   // inverse 'q'
            '{7'h0D, 1'b0, 0, 0},
            '{7'h0A, 1'b0, 0, 1},
            '{7'h01, 1'b0, 0, 1},   // ignored control code
            '{7'h7E, 1'b0, 1, 1},
            '{7'h7F, 1'b0, 1, 1},   // DEL is not printable
            '{7'h0A, 1'b0, 0, 2}
        };

        model_clear();
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(out_char_ready), 32'd0);
        check("reset_pixel", 32'(out_pixel), 32'(BG));
        check_cursor("reset_cursor", 0, 0);

        rst_n = 1'b1;
        busy_len(n);
        check("clear_len_after_reset", n, 240);
        check_cursor("cursor_after_clear", 0, 0);
        pix_at(0, 0, p);
        check("pixel_0_0_blank", 32'(p), 32'(BG));

        // reset in the middle of a form-feed clear restarts the full clear
        send(7'h0C, 1'b0);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_ready", 32'(out_char_ready), 32'd0);
        rst_n = 1'b1;
        model_clear();
        busy_len(n);
        check("clear_len_after_midreset", n, 240);

        // single 'A'
        send(7'h41, 1'b0);
        check_cursor("cursor_after_A", 1, 0);
        pix_at(3, 2, p);
        check("A_row2_col3", 32'(p), 32'(FG));
        pix_at(0, 2, p);
        check("A_row2_col0", 32'(p), 32'(BG));
        stream("A_glyph", 128, 3, 0, 0);

        // fill the row, wrap to the next
        for (int i = 0; i < 29; i++) send(7'($urandom_range(33, 126)), 1'($urandom_range(0, 1)));
        check_cursor("cursor_after_30", 0, 1);
        send(7'h42, 1'b0);
        check_cursor("cursor_after_31", 1, 1);
        stream("char31_cell", 128, 3, 0, 1);
        stream("row0_raster", 16 * 240, 2, 0, 0);

        // scroll at the bottom row
        send(7'h0C, 1'b0);
        busy_len(n);
        check("ff_clear_len", n, 240);
        check_cursor("cursor_after_ff", 0, 0);
        send(7'h0A, 1'b0);
        send(7'h58, 1'b0);
        check_cursor("cursor_after_X", 1, 1);
        for (int i = 0; i < 6; i++) begin
            send(7'h0A, 1'b0);
            check("lf_no_stall", 32'(out_char_ready), 32'd1);
        end
        check_cursor("cursor_at_bottom", 0, 7);
        send(7'h0A, 1'b0);
        busy_len(n);
        check("scroll_clrline_len", n, 30);
        check_cursor("cursor_after_scroll", 0, 7);
        pix_at(0, 3, p);
        check("X_on_row0", 32'(p), 32'(FG));
        stream("scroll_row0", 16 * 240, 2, 0, 0);
        stream("scroll_row7", 16 * 240, 2, 0, 112);
        send(7'h08, 1'b0);
        check_cursor("bs_at_col0", 0, 7);

        // table of cursor-movement vectors from a cleared screen
        send(7'h0C, 1'b0);
        busy_len(n);
        check("ff2_clear_len", n, 240);
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].ch, vecs[i].inv);
            check_cursor($sformatf("vec%0d_cursor", i), vecs[i].ex, vecs[i].ey);
        end
        stream("vec_row0_cells", 128, 3, 0, 0);
        stream("vec_random", 300, 0, 0, 0);

        // random character soak
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 70)      c = 7'($urandom_range(32, 126));
            else if (n < 80) c = 7'h0A;
            else if (n < 85) c = 7'h0D;
            else if (n < 92) c = 7'h08;
            else if (n < 93) c = 7'h0C;
            else             c = 7'($urandom_range(0, 31));
            send(c, 1'($urandom_range(0, 1)));
            if (c == 7'h0C) busy_len(n);
            check_cursor("soak_cursor", cx, cy);
        end
        busy_len(n);
        stream("soak_pixels", 500, 0, 0, 0);

        // out-of-range coordinates
        pix_at(0, 130, p);
        check("pixel_y130_x0", 32'(p), 32'(BG));
        pix_at(100, 130, p);
        check("pixel_y130_x100", 32'(p), 32'(BG));
        pix_at(245, 10, p);
        check("pixel_x245", 32'(p), 32'(BG));

        // cursor blink
        in_show_cursor = 1'b1;
        stream("blink_cursor_cell", 24, 1, cx * 8 + 3, cy * 16 + 15);
        stream("blink_random", 300, 0, 0, 0);
        in_show_cursor = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
